// File: rtl/riscv_instr_prefetcher.sv
// Instruction prefetcher: issues word fetches on a req/gnt/rvalid bus and buffers
// responses in a small FIFO for the IF stage. Flushes on branch and drops stale responses.
module riscv_instr_prefetcher #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [1:0]    MAX_OUT_C = 2'(MAX_OUTSTANDING);

    logic [31:0]    fifo_data [DEPTH];
    logic [31:0]    fifo_addr [DEPTH];
    logic [DEPTH-1:0] fifo_err;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  occ;
    logic [CW-1:0]  credit;
    logic [1:0]     out;
    logic [1:0]     disc;
    logic [31:0]    fetch_addr;
    logic [31:0]    resp_addr;
    logic [31:0]    branch_word;
    logic [31:0]    push_data;
    logic           stopped;
    logic           grant;
    logic           pop;
    logic           push;
    logic           drop;
    logic           branch_lsb_unused;

    assign branch_lsb_unused = branch_addr_i[0];
    assign branch_word = {branch_addr_i[31:2], 2'b00};

    assign valid_o = (occ != '0);
    assign rdata_o = fifo_data[rd_ptr];
    assign addr_o  = fifo_addr[rd_ptr];
    assign err_o   = fifo_err[rd_ptr];
    assign busy_o  = (out != 2'd0);

    assign pop   = valid_o & ready_i;
    assign grant = instr_req_o & instr_gnt_i;
    assign drop  = instr_rvalid_i & (disc != 2'd0);
    assign push  = instr_rvalid_i & ~drop & ~branch_i;

    // Slots already promised: buffered entries (net of this cycle's pop) plus live requests.
    assign credit = occ - CW'(pop) + CW'(out) - CW'(disc);

    assign instr_req_o  = req_i & ~stopped & (out < MAX_OUT_C) & (credit < DEPTH_C);
    assign instr_addr_o = branch_i ? branch_word : fetch_addr;

    // A halfword-aligned restart keeps only the upper half of the first word.
    assign push_data = resp_addr[1] ? {16'h0000, instr_rdata_i[31:16]} : instr_rdata_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
            fifo_err   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            out        <= 2'd0;
            disc       <= 2'd0;
            fetch_addr <= '0;
            resp_addr  <= '0;
            stopped    <= 1'b0;
        end else begin
            out <= out + 2'(grant) - 2'(instr_rvalid_i);
            if (branch_i) begin
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                // Only requests older than this cycle are stale; a grant taken now
                // is the first fetch of the new stream.
                disc       <= out - 2'(instr_rvalid_i);
                resp_addr  <= {branch_addr_i[31:1], 1'b0};
                stopped    <= 1'b0;
                fetch_addr <= grant ? branch_word + 32'd4 : branch_word;
            end else begin
                if (grant) fetch_addr <= fetch_addr + 32'd4;
                if (drop)  disc <= disc - 2'd1;
                if (pop)   rd_ptr <= rd_ptr + AW'(1);
                occ <= occ + CW'(push) - CW'(pop);
                if (push) begin
                    fifo_data[wr_ptr] <= push_data;
                    fifo_addr[wr_ptr] <= resp_addr;
                    fifo_err[wr_ptr]  <= instr_err_i;
                    wr_ptr            <= wr_ptr + AW'(1);
                    resp_addr         <= {resp_addr[31:2], 2'b00} + 32'd4;
                    if (instr_err_i) stopped <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!instr_rvalid_i || out != 2'd0);
            assert (disc <= out);
            assert (!(push && occ == DEPTH_C && !pop));
            assert (!(pop && occ == '0));
        end
    end
endmodule

// File: tb/tb_riscv_instr_prefetcher.sv
// Directed bench for riscv_instr_prefetcher: a one-cycle-latency memory responder
// and hand-computed expectations at each step.
module tb_riscv_instr_prefetcher;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic        busy_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    int          checks = 0;
    int          errors = 0;
    int          grant_cnt = 0;
    logic        resp_en;
    logic [31:0] err_addr;
    logic [31:0] pend_q[$];

    riscv_instr_prefetcher #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .ready_i(ready_i), .valid_o(valid_o),
        .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o), .busy_o(busy_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'hAAAA_BBBB;
        return 32'hDA7A_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record a grant before the edge, answer one pending request after it.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        logic [31:0] r;
        #1;
        g = instr_req_o & instr_gnt_i;
        a = instr_addr_o;
        @(posedge clk);
        if (g) begin
            pend_q.push_back(a);
            grant_cnt++;
        end
        #1;
        if (resp_en && pend_q.size() != 0) begin
            r = pend_q.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(r);
            instr_err_i    = (r == err_addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            instr_err_i    = 1'b0;
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!valid_o && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, 32'(valid_o), 32'd1);
    endtask

    task automatic do_branch(input logic [31:0] a);
        branch_i = 1'b1;
        branch_addr_i = a;
        tick();
        branch_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0; ready_i = 1'b0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
        resp_en = 1'b1; err_addr = 32'hFFFF_FFFF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_iaddr", instr_addr_o, 32'd0);
        rst = 1'b0;
        tick();

        // Straight-line fetch from 0x100
        req_i = 1'b1; instr_gnt_i = 1'b1; ready_i = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h100;
        #1;
        chk("br_req", 32'(instr_req_o), 32'd1);
        chk("br_iaddr", instr_addr_o, 32'h100);
        tick();
        branch_i = 1'b0;
        #1;
        chk("sl_valid_c1", 32'(valid_o), 32'd0);
        chk("sl_iaddr_c1", instr_addr_o, 32'h104);
        tick();
        chk("sl_valid_c2", 32'(valid_o), 32'd1);
        chk("sl_head0_addr", addr_o, 32'h100);
        chk("sl_head0_data", rdata_o, 32'hDA7A_0100);
        #1;
        chk("sl_iaddr_c2", instr_addr_o, 32'h108);
        tick();
        chk("sl_head1_addr", addr_o, 32'h104);
        chk("sl_head1_data", rdata_o, 32'hDA7A_0104);

        // Backpressure: exactly four grants fill the FIFO
        ready_i = 1'b0;
        grant_cnt = 0;
        do_branch(32'h700);
        repeat (6) tick();
        chk("bp_grants", 32'(grant_cnt), 32'd4);
        chk("bp_valid", 32'(valid_o), 32'd1);
        chk("bp_head", addr_o, 32'h700);
        chk("bp_busy", 32'(busy_o), 32'd0);
        #1;
        chk("bp_req_blocked", 32'(instr_req_o), 32'd0);
        ready_i = 1'b1;
        #1;
        chk("bp_req_resume", 32'(instr_req_o), 32'd1);
        chk("bp_iaddr_resume", instr_addr_o, 32'h710);
        tick();
        chk("bp_head_next", addr_o, 32'h704);

        // Drain everything
        req_i = 1'b0;
        repeat (8) tick();
        chk("drain_valid", 32'(valid_o), 32'd0);
        chk("drain_busy", 32'(busy_o), 32'd0);

        // Branch while two requests are outstanding
        resp_en = 1'b0; req_i = 1'b1; ready_i = 1'b0;
        do_branch(32'h100);
        tick();
        chk("o2_busy", 32'(busy_o), 32'd1);
        #1;
        chk("o2_req_blocked", 32'(instr_req_o), 32'd0);
        resp_en = 1'b1;
        do_branch(32'h200);
        wait_valid("o2_wait", 10);
        chk("o2_head_addr", addr_o, 32'h200);
        chk("o2_head_data", rdata_o, 32'hDA7A_0200);

        // Halfword restart at 0x302
        do_branch(32'h302);
        wait_valid("hw_wait", 10);
        chk("hw_addr", addr_o, 32'h302);
        chk("hw_data", rdata_o, 32'h0000_AAAA);
        chk("hw_err", 32'(err_o), 32'd0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        wait_valid("hw_wait2", 10);
        chk("hw_next_addr", addr_o, 32'h304);
        chk("hw_next_data", rdata_o, 32'hDA7A_0304);

        // Bus error at 0x40C stops fetching until the next branch
        err_addr = 32'h40C;
        do_branch(32'h400);
        repeat (10) tick();
        chk("er_busy", 32'(busy_o), 32'd0);
        chk("er_head0", addr_o, 32'h400);
        ready_i = 1'b1;
        repeat (3) tick();
        ready_i = 1'b0;
        chk("er_addr", addr_o, 32'h40C);
        chk("er_flag", 32'(err_o), 32'd1);
        chk("er_data", rdata_o, 32'hDA7A_040C);
        #1;
        chk("er_req_stopped", 32'(instr_req_o), 32'd0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("er_empty", 32'(valid_o), 32'd0);
        #1;
        chk("er_req_still", 32'(instr_req_o), 32'd0);
        err_addr = 32'hFFFF_FFFF;
        do_branch(32'h500);
        wait_valid("er_resume_wait", 10);
        chk("er_resume_addr", addr_o, 32'h500);
        chk("er_resume_err", 32'(err_o), 32'd0);

        // Branch coincident with rvalid, grant and pop
        ready_i = 1'b1;
        repeat (6) tick();
        chk("sim_pre_valid", 32'(valid_o), 32'd1);
        #1;
        chk("sim_pre_req", 32'(instr_req_o), 32'd1);
        do_branch(32'h600);
        chk("sim_flushed", 32'(valid_o), 32'd0);
        chk("sim_busy", 32'(busy_o), 32'd1);
        tick();
        chk("sim_first_valid", 32'(valid_o), 32'd1);
        chk("sim_first_addr", addr_o, 32'h600);
        chk("sim_first_data", rdata_o, 32'hDA7A_0600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
